key_press_decoder: RTL and testbench

Consumes the debounced one-cycle `key_down`/`key_up` pulses produced by the key debounce stage and classifies each button gesture. The gestures are single click, double click, long press, and auto-repeat while held. Each gesture is reported as a one-cycle command pulse to the cipher control logic, for example for mode select, start, or key load. One instance sits behind each debounced button.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_press_decoder.sv | 149 ++++++++++++++
 tb/tb_key_press_decoder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button gesture path.
// Holds the one-hot gesture state encoding and the ms-to-cycles helper
// that both the debounce stage and the gesture decoder use to turn
// millisecond timings into counter terminal values.
package key_pkg;

  // One-hot gesture states of the decoder FSM.
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    PRESS1 = 5'b00010,
    WAIT2  = 5'b00100,
    PRESS2 = 5'b01000,
    LONG   = 5'b10000
  } key_state_e;

  // Terminal count for a counter that starts at 0: an interval of ms
  // milliseconds ends when the counter equals this value.
  function automatic logic [31:0] ms2cyc(input int unsigned clk_freq,
                                         input int unsigned ms);
    logic [31:0] per_ms;
    per_ms = clk_freq / 32'd1000;
    return (per_ms * ms) - 32'd1;
  endfunction

endpackage

// File: rtl/key_press_decoder.sv
// Gesture classifier for one debounced push button.
// Turns the press/release pulses of the debounce stage into one-cycle
// command pulses: single click, double click, long press and auto-repeat
// while the long press is held.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset; aborts any gesture silently
//   key_down     one-cycle pulse, debounced press
//   key_up       one-cycle pulse, debounced release
//   short_click  one-cycle pulse, single click completed
//   double_click one-cycle pulse, double click completed
//   long_press   one-cycle pulse, hold time reached LONG_MS
//   key_rep      one-cycle pulse every REPEAT_MS while in long hold
//   holding      level, high while in long hold
module key_press_decoder
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_down,
  input  logic key_up,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic key_rep,
  output logic holding
);

  localparam logic [31:0] LONG_CYC   = ms2cyc(CLK_FREQ, LONG_MS);
  localparam logic [31:0] DCLICK_CYC = ms2cyc(CLK_FREQ, DCLICK_MS);
  localparam logic [31:0] REPEAT_CYC = ms2cyc(CLK_FREQ, REPEAT_MS);

  key_state_e  state_r;
  key_state_e  state_nx_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_nx_s;
  logic        press_s;
  logic        short_nx_s;
  logic        double_nx_s;
  logic        long_nx_s;
  logic        rep_nx_s;
  logic        holding_nx_s;

  // A simultaneous press and release is treated as a release only.
  assign press_s = key_down & ~key_up;

  // Next-state, shared counter and output pulse decode.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r + 32'd1;
    short_nx_s  = 1'b0;
    double_nx_s = 1'b0;
    long_nx_s   = 1'b0;
    rep_nx_s    = 1'b0;
    unique case (state_r)
      IDLE: begin
        // The counter free-runs here; its value is never consulted in IDLE.
        if (press_s) begin
          state_nx_s = PRESS1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PRESS1: begin
        // Reaching the long threshold wins over a release in the same cycle.
        if (cnt_r == LONG_CYC) begin
          long_nx_s  = 1'b1;
          state_nx_s = LONG;
        end else if (key_up) begin
          state_nx_s = WAIT2;
        end else begin
          state_nx_s = PRESS1;
        end
      end
      WAIT2: begin
        // A second press arriving on the timeout cycle still makes a double.
        if (press_s) begin
          state_nx_s = PRESS2;
        end else if (cnt_r == DCLICK_CYC) begin
          short_nx_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT2;
        end
      end
      PRESS2: begin
        // Holding the second press long reports the first click plus a long press.
        if (cnt_r == LONG_CYC) begin
          short_nx_s = 1'b1;
          long_nx_s  = 1'b1;
          state_nx_s = LONG;
        end else if (key_up) begin
          double_nx_s = 1'b1;
          state_nx_s  = IDLE;
        end else begin
          state_nx_s = PRESS2;
        end
      end
      LONG: begin
        // Release ends the hold silently and suppresses a coincident repeat.
        if (key_up) begin
          state_nx_s = IDLE;
        end else if (cnt_r == REPEAT_CYC) begin
          rep_nx_s = 1'b1;
          cnt_nx_s = 32'd0;
        end else begin
          state_nx_s = LONG;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    if (state_nx_s != state_r) begin
      cnt_nx_s = 32'd0;
    end else begin
      cnt_nx_s = cnt_nx_s;
    end
    holding_nx_s = (state_nx_s == LONG);
  end

  // State, counter and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 32'd0;
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      key_rep      <= 1'b0;
      holding      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      short_click  <= short_nx_s;
      double_click <= double_nx_s;
      long_press   <= long_nx_s;
      key_rep      <= rep_nx_s;
      holding      <= holding_nx_s;
    end
  end

endmodule

// File: tb/tb_key_press_decoder.sv
// Self-checking bench for key_press_decoder with 1 ms clock cycles.
// Directed gesture scenarios plus randomized press/release traffic, all
// compared against a timestamp-based gesture model kept in this file.
module tb_key_press_decoder;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned LONG_MS   = 20;
  localparam int unsigned DCLICK_MS = 5;
  localparam int unsigned REPEAT_MS = 4;
  localparam int LONG_C   = CLK_FREQ / 1000 * LONG_MS - 1;
  localparam int DCLICK_C = CLK_FREQ / 1000 * DCLICK_MS - 1;
  localparam int REP_C    = CLK_FREQ / 1000 * REPEAT_MS - 1;

  localparam int G_IDLE  = 0;
  localparam int G_DOWN1 = 1;
  localparam int G_GAP   = 2;
  localparam int G_DOWN2 = 3;
  localparam int G_HELD  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_down = 1'b0;
  logic key_up = 1'b0;
  logic short_click, double_click, long_press, key_rep, holding;
  logic [4:0] dut_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference gesture model: phase, edge count, edge of phase start.
  int m_phase = G_IDLE;
  int cyc = 0;
  int m_t = 0;
  logic [4:0] m_out = 5'b0;

  assign dut_out = {short_click, double_click, long_press, key_rep, holding};

  always #5 clk = ~clk;

  key_press_decoder #(
    .CLK_FREQ (CLK_FREQ),
    .LONG_MS  (LONG_MS),
    .DCLICK_MS(DCLICK_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_down    (key_down),
    .key_up      (key_up),
    .short_click (short_click),
    .double_click(double_click),
    .long_press  (long_press),
    .key_rep     (key_rep),
    .holding     (holding)
  );

  task automatic model_reset();
    m_phase = G_IDLE;
    cyc     = 0;
    m_t     = 0;
    m_out   = 5'b0;
  endtask

  // Advance the model by one clock edge; age = whole cycles spent in phase.
  task automatic model_edge(input logic d, input logic u);
    logic s, dc, lp, rp;
    int age;
    s = 1'b0; dc = 1'b0; lp = 1'b0; rp = 1'b0;
    cyc = cyc + 1;
    age = cyc - 1 - m_t;
    if (m_phase == G_IDLE) begin
      if (d && !u) begin m_phase = G_DOWN1; m_t = cyc; end
    end else if (m_phase == G_DOWN1) begin
      if (age == LONG_C) begin lp = 1'b1; m_phase = G_HELD; m_t = cyc; end
      else if (u) begin m_phase = G_GAP; m_t = cyc; end
    end else if (m_phase == G_GAP) begin
      if (d && !u) begin m_phase = G_DOWN2; m_t = cyc; end
      else if (age == DCLICK_C) begin s = 1'b1; m_phase = G_IDLE; m_t = cyc; end
    end else if (m_phase == G_DOWN2) begin
      if (age == LONG_C) begin s = 1'b1; lp = 1'b1; m_phase = G_HELD; m_t = cyc; end
      else if (u) begin dc = 1'b1; m_phase = G_IDLE; m_t = cyc; end
    end else begin
      if (u) begin m_phase = G_IDLE; m_t = cyc; end
      else if (age == REP_C) begin rp = 1'b1; m_t = cyc; end
    end
    m_out = {s, dc, lp, rp, (m_phase == G_HELD)};
  endtask

  // Drive one cycle of inputs from a falling edge and return at the next one.
  task automatic tick(input logic d, input logic u);
    key_down = d;
    key_up   = u;
    @(posedge clk);
    model_edge(d, u);
    @(negedge clk);
    key_down = 1'b0;
    key_up   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (dut_out !== 5'b0) begin
      n_err++;
      $display("FAIL reset_value got=%b exp=%b", dut_out, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, dut_out, m_out);
      end
    end
  endtask

  task automatic test_single_click();
    int first_short = -1;
    for (int k = 0; k < 14; k++) begin
      tick(k == 0, k == 3);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL single_click edge=%0d got=%b exp=%b", k + 1, dut_out, m_out);
      end
      if (short_click && first_short < 0) first_short = k + 1;
    end
    n_vec++;
    if (first_short !== 3 + DCLICK_C + 2) begin
      n_err++;
      $display("FAIL single_click_time got=%0d exp=%0d", first_short, 3 + DCLICK_C + 2);
    end
  endtask

  task automatic test_double_click();
    int first_dbl = -1;
    int n_short = 0;
    for (int k = 0; k < 16; k++) begin
      tick(k == 0 || k == 6, k == 3 || k == 9);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL double_click edge=%0d got=%b exp=%b", k + 1, dut_out, m_out);
      end
      if (double_click && first_dbl < 0) first_dbl = k + 1;
      if (short_click) n_short++;
    end
    n_vec++;
    if (first_dbl !== 10 || n_short !== 0) begin
      n_err++;
      $display("FAIL double_click_time got=%0d/%0d exp=10/0", first_dbl, n_short);
    end
  endtask

  task automatic test_long_press();
    int first_long = -1;
    int first_hold = -1;
    int first_rep = -1;
    int last_hold = -1;
    int n_rep = 0;
    for (int k = 0; k < 46; k++) begin
      tick(k == 0, k == 40);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL long_press edge=%0d got=%b exp=%b", k + 1, dut_out, m_out);
      end
      if (long_press && first_long < 0) first_long = k + 1;
      if (holding && first_hold < 0) first_hold = k + 1;
      if (holding) last_hold = k + 1;
      if (key_rep) begin
        n_rep++;
        if (first_rep < 0) first_rep = k + 1;
      end
    end
    n_vec++;
    if (first_long !== LONG_C + 2 || first_hold !== LONG_C + 2 || last_hold !== 40) begin
      n_err++;
      $display("FAIL long_press_time got=%0d/%0d/%0d exp=%0d/%0d/40",
               first_long, first_hold, last_hold, LONG_C + 2, LONG_C + 2);
    end
    n_vec++;
    if (first_rep !== first_hold + REP_C + 1 || n_rep !== 4) begin
      n_err++;
      $display("FAIL key_rep_time got=%0d/%0d exp=%0d/4", first_rep, n_rep, first_hold + REP_C + 1);
    end
  endtask

  task automatic test_boundaries();
    int n_short = 0;
    // Release on the exact long-threshold cycle: long press still wins.
    for (int k = 0; k < 26; k++) begin
      tick(k == 0, k == LONG_C + 1 || k == 24);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL up_at_long edge=%0d got=%b exp=%b", k + 1, dut_out, m_out);
      end
      if (k == LONG_C + 2) begin
        n_vec++;
        if (holding !== 1'b1) begin
          n_err++;
          $display("FAIL up_at_long_hold got=%b exp=1", holding);
        end
      end
    end
    // Second press on the gap-timeout cycle becomes a double click.
    for (int k = 0; k < 16; k++) begin
      tick(k == 0 || k == 4 + DCLICK_C, k == 3 || k == 11);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL down_at_timeout edge=%0d got=%b exp=%b", k + 1, dut_out, m_out);
      end
      if (short_click) n_short++;
    end
    n_vec++;
    if (n_short !== 0) begin
      n_err++;
      $display("FAIL down_at_timeout_short got=%0d exp=0", n_short);
    end
  endtask

  task automatic test_violations();
    int first_short = -1;
    // Press ignored in PRESS1, simultaneous press+release acts as release.
    for (int k = 0; k < 12; k++) begin
      tick(k == 0 || k == 1 || k == 2, k == 2);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL both_in_press1 edge=%0d got=%b exp=%b", k + 1, dut_out, m_out);
      end
      if (short_click && first_short < 0) first_short = k + 1;
    end
    n_vec++;
    if (first_short !== 2 + DCLICK_C + 2) begin
      n_err++;
      $display("FAIL both_in_press1_time got=%0d exp=%0d", first_short, 2 + DCLICK_C + 2);
    end
    // Stray release in IDLE.
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, k == 0);
      n_vec++;
      if (dut_out !== 5'b0) begin
        n_err++;
        $display("FAIL stray_up edge=%0d got=%b exp=%b", k + 1, dut_out, 5'b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 26; k++) tick(k == 0, 1'b0);
    n_vec++;
    if (holding !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_setup got=%b exp=1", holding);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dut_out !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_async got=%b exp=%b", dut_out, 5'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, k == 5);
      n_vec++;
      if (dut_out !== 5'b0) begin
        n_err++;
        $display("FAIL reset_mid_quiet edge=%0d got=%b exp=%b", k + 1, dut_out, 5'b0);
      end
    end
  endtask

  task automatic test_random();
    int pd, pu;
    pd = 8; pu = 8;
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) begin
        pd = $urandom_range(2, 10);
        pu = ($urandom_range(0, 2) == 0) ? 40 : $urandom_range(2, 12);
      end
      tick($urandom_range(1, pd) == 1, $urandom_range(1, pu) == 1);
      n_vec++;
      if (dut_out !== m_out) begin
        n_err++;
        $display("FAIL random k=%0d got=%b exp=%b", k, dut_out, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_boundaries();
    test_violations();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
